// File: rtl/tlb_set_assoc_if.sv
// Request/response and page-table-walker signal bundle for tlb_set_assoc.
// The TLB binds to the slave modport; the load/store unit plus walker side binds to master.
`timescale 1ns/1ps
interface tlb_set_assoc_if #(
  parameter int PPN_W = 20
);
  // Handshake rules:
  // - req: a request transfers at a rising edge where req_valid && req_ready.
  //   The requester keeps req_vaddr and req_write stable while req_valid is high.
  // - resp: resp_valid is a single-cycle strobe with no backpressure.
  // - walk: walk_req_valid and walk_vpn are held until the walker pulses walk_resp_valid.
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_vaddr;
  logic              req_write;
  logic              resp_valid;
  logic [PPN_W+11:0] resp_paddr;
  logic [1:0]        resp_fault;
  logic              walk_req_valid;
  logic [19:0]       walk_vpn;
  logic              walk_resp_valid;
  logic [PPN_W-1:0]  walk_ppn;
  logic [1:0]        walk_perms;
  logic              walk_fault;

  modport slave (
    input  req_valid, req_vaddr, req_write,
    input  walk_resp_valid, walk_ppn, walk_perms, walk_fault,
    output req_ready, resp_valid, resp_paddr, resp_fault,
    output walk_req_valid, walk_vpn
  );

  modport master (
    output req_valid, req_vaddr, req_write,
    output walk_resp_valid, walk_ppn, walk_perms, walk_fault,
    input  req_ready, resp_valid, resp_paddr, resp_fault,
    input  walk_req_valid, walk_vpn
  );
endinterface

// File: rtl/tlb_set_assoc.sv
// Set-associative TLB for 4 KiB pages. It performs a one-cycle lookup, refills from the
// page-table walker on a miss, and uses per-set round-robin replacement once a set is full.
`timescale 1ns/1ps
module tlb_set_assoc #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int PPN_W    = 20,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tlb_set_assoc_if.slave       tlb,
  input  logic                 flush,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [1:0]           dbg_state
);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_WALK   = 2'd2;

  logic [1:0]          state;
  logic [31:0]         vaddr_q;
  logic                write_q;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_BITS-1:0] rr_q    [NUM_SETS];
  logic [19:0]         tag_q   [NUM_SETS][NUM_WAYS];
  logic [PPN_W-1:0]    ppn_q   [NUM_SETS][NUM_WAYS];
  logic [1:0]          perms_q [NUM_SETS][NUM_WAYS];

  logic [19:0]         vpn;
  logic [SET_BITS-1:0] set_idx;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic                has_invalid;
  logic [WAY_BITS-1:0] inv_way;
  logic [WAY_BITS-1:0] victim;
  logic [PPN_W-1:0]    hit_ppn;
  logic [1:0]          hit_perms;
  logic                perm_fault;
  logic                fill_en;

  assign vpn     = vaddr_q[31:12];
  assign set_idx = vaddr_q[12 +: SET_BITS];

  // Both scans run from the top way down so that the lowest matching or invalid way wins.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == vpn)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_BITS'(w);
      end
    end
  end

  assign victim     = has_invalid ? inv_way : rr_q[set_idx];
  assign hit_ppn    = ppn_q[set_idx][hit_way];
  assign hit_perms  = perms_q[set_idx][hit_way];
  assign perm_fault = write_q ? !hit_perms[1] : !hit_perms[0];

  // A flush at the same edge as a refill suppresses the write, so the replay misses again.
  assign fill_en = (state == ST_WALK) && tlb.walk_resp_valid && !tlb.walk_fault && !flush;

  assign tlb.req_ready = (state == ST_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      vaddr_q            <= '0;
      write_q            <= 1'b0;
      tlb.resp_valid     <= 1'b0;
      tlb.resp_paddr     <= '0;
      tlb.resp_fault     <= 2'b00;
      tlb.walk_req_valid <= 1'b0;
      tlb.walk_vpn       <= '0;
      hit_count          <= '0;
      miss_count         <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      tlb.resp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tlb.req_valid) begin
            vaddr_q <= tlb.req_vaddr;
            write_q <= tlb.req_write;
            state   <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (hit) begin
            tlb.resp_valid <= 1'b1;
            tlb.resp_paddr <= {hit_ppn, vaddr_q[11:0]};
            tlb.resp_fault <= perm_fault ? 2'b01 : 2'b00;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            state <= ST_IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            tlb.walk_req_valid <= 1'b1;
            tlb.walk_vpn       <= vpn;
            state              <= ST_WALK;
          end
        end

        ST_WALK: begin
          if (tlb.walk_resp_valid) begin
            tlb.walk_req_valid <= 1'b0;
            if (tlb.walk_fault) begin
              tlb.resp_valid <= 1'b1;
              tlb.resp_paddr <= '0;
              tlb.resp_fault <= 2'b10;
              state          <= ST_IDLE;
            end else begin
              state <= ST_LOOKUP;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end else if (fill_en) begin
        valid_q[set_idx][victim] <= 1'b1;
      end

      // The pointer only advances when it actually chose the victim in a full set.
      if (fill_en && !has_invalid) rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[set_idx][victim]   <= vpn;
      ppn_q[set_idx][victim]   <= tlb.walk_ppn[PPN_W-1:0];
      perms_q[set_idx][victim] <= tlb.walk_perms;
    end
  end
endmodule

// File: tb/tb_tlb_set_assoc.sv
// Directed bench for tlb_set_assoc: cold miss, hit latency, permissions, round-robin
// replacement, page faults, flush interactions and reset during a walk.
`timescale 1ns/1ps
module tb_tlb_set_assoc;
  localparam int PPN_W = 20;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [1:0]       dbg_state;

  tlb_set_assoc_if #(.PPN_W(PPN_W)) tif ();

  tlb_set_assoc #(
    .NUM_SETS(16), .NUM_WAYS(4), .PPN_W(PPN_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tlb        (tif.slave),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Walker model configuration plus per-access results
  logic [PPN_W-1:0]  w_ppn;
  logic [1:0]        w_perms;
  logic              w_fault;
  logic              flush_on_walk;
  int                walks;
  int                lat;
  logic              got_resp;
  logic [19:0]       last_walk_vpn;
  logic              walk_req_after;
  logic [PPN_W+11:0] r_paddr;
  logic [1:0]        r_fault;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one request and answer every walk it raises, until the response arrives.
  task automatic access(input logic [31:0] addr, input logic wr);
    int cyc;
    walks = 0; got_resp = 1'b0; lat = 0; walk_req_after = 1'b0;
    @(negedge clk);
    tif.req_valid = 1'b1; tif.req_vaddr = addr; tif.req_write = wr;
    @(posedge clk); #1;
    tif.req_valid = 1'b0;
    cyc = 0;
    while (!got_resp && cyc < 40) begin
      @(negedge clk); cyc++;
      if (tif.resp_valid) begin
        got_resp = 1'b1; lat = cyc;
        r_paddr = tif.resp_paddr; r_fault = tif.resp_fault;
      end else if (tif.walk_req_valid) begin
        walks++;
        last_walk_vpn       = tif.walk_vpn;
        tif.walk_resp_valid = 1'b1;
        tif.walk_ppn        = w_ppn;
        tif.walk_perms      = w_perms;
        tif.walk_fault      = w_fault;
        if (flush_on_walk && walks == 1) flush = 1'b1;
        @(posedge clk); #1;
        walk_req_after      = tif.walk_req_valid;
        tif.walk_resp_valid = 1'b0;
        flush               = 1'b0;
      end
    end
    check("resp_timeout", got_resp, 1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_on_walk = 1'b0;
    tif.req_valid = 1'b0; tif.req_vaddr = '0; tif.req_write = 1'b0;
    tif.walk_resp_valid = 1'b0; tif.walk_ppn = '0; tif.walk_perms = 2'b00; tif.walk_fault = 1'b0;
    w_ppn = '0; w_perms = 2'b11; w_fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", tif.req_ready, 1);
    check("rst_resp_valid", tif.resp_valid, 0);
    check("rst_walk_req", tif.walk_req_valid, 0);
    check("rst_paddr", tif.resp_paddr, 0);
    check("rst_fault", tif.resp_fault, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    // Cold miss
    w_ppn = 20'hABCDE; w_perms = 2'b11;
    access(32'h1234_5678, 1'b0);
    check("cold_walks", walks, 1);
    check("cold_walk_vpn", last_walk_vpn, 20'h12345);
    check("cold_walk_drop", walk_req_after, 0);
    check("cold_paddr", r_paddr, 32'hABCDE678);
    check("cold_fault", r_fault, 2'b00);
    check("cold_misses", miss_count, 1);
    check("cold_hits", hit_count, 1);

    // Hit with write
    access(32'h1234_5FFC, 1'b1);
    check("hit_walks", walks, 0);
    check("hit_latency", lat, 2);
    check("hit_paddr", r_paddr, 32'hABCDEFFC);
    check("hit_fault", r_fault, 2'b00);
    check("hit_hits", hit_count, 2);
    check("hit_ready_again", tif.req_ready, 1);

    // Read-only page: write faults, read does not
    w_ppn = 20'h11111; w_perms = 2'b01;
    access(32'h0004_2000, 1'b1);
    check("perm_walks", walks, 1);
    check("perm_wr_fault", r_fault, 2'b01);
    check("perm_wr_paddr", r_paddr, 32'h1111_1000);
    access(32'h0004_2000, 1'b0);
    check("perm_rd_walks", walks, 0);
    check("perm_rd_fault", r_fault, 2'b00);
    check("perm_hits", hit_count, 4);
    check("perm_misses", miss_count, 2);

    // Fill set 0 past its four ways
    w_perms = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      w_ppn = 20'h00100 + 20'(i * 16);
      access(32'(i * 16) << 12, 1'b0);
      check("repl_fill_walks", walks, 1);
    end
    access(32'h0005_0000, 1'b0);
    check("repl_50_hit", walks, 0);
    check("repl_50_paddr", r_paddr, 32'h0015_0000);
    w_ppn = 20'h00110;
    access(32'h0001_0000, 1'b0);
    check("repl_10_miss", walks, 1);
    check("repl_10_paddr", r_paddr, 32'h0011_0000);
    w_ppn = 20'h00120;
    access(32'h0002_0000, 1'b0);
    check("repl_20_evicted", walks, 1);
    access(32'h0004_0000, 1'b0);
    check("repl_40_kept", walks, 0);
    access(32'h0005_0000, 1'b0);
    check("repl_50_kept", walks, 0);
    check("repl_misses", miss_count, 9);
    check("repl_hits", hit_count, 14);

    // Page fault: no fill, retry walks again
    w_fault = 1'b1;
    access(32'h0007_7123, 1'b0);
    check("pf_walks", walks, 1);
    check("pf_fault", r_fault, 2'b10);
    check("pf_paddr", r_paddr, 0);
    access(32'h0007_7123, 1'b0);
    check("pf_rewalk", walks, 1);
    check("pf_misses", miss_count, 11);
    check("pf_hits", hit_count, 14);
    w_fault = 1'b0;

    // Flush coincident with the walker reply
    w_ppn = 20'h0BEEF; flush_on_walk = 1'b1;
    access(32'h0009_9ABC, 1'b0);
    flush_on_walk = 1'b0;
    check("fw_two_walks", walks, 2);
    check("fw_paddr", r_paddr, 32'h0BEE_FABC);
    check("fw_misses", miss_count, 13);
    access(32'h0009_9ABC, 1'b0);
    check("fw_then_hit", walks, 0);

    // Flush in IDLE
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    access(32'h0009_9ABC, 1'b0);
    check("fi_miss_a", walks, 1);
    access(32'h0004_0000, 1'b0);
    check("fi_miss_b", walks, 1);
    check("fi_paddr_b", r_paddr, 32'h0BEE_F000);

    // Flush at the same edge as a hitting lookup still responds
    @(negedge clk);
    tif.req_valid = 1'b1; tif.req_vaddr = 32'h0004_0000; tif.req_write = 1'b0;
    @(posedge clk); #1;
    tif.req_valid = 1'b0;
    check("fl_lookup_ready", tif.req_ready, 0);
    check("fl_lookup_state", dbg_state, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_resp_valid", tif.resp_valid, 1);
    check("fl_resp_paddr", tif.resp_paddr, 32'h0BEE_F000);
    access(32'h0004_0000, 1'b0);
    check("fl_then_miss", walks, 1);
    check("fl_misses", miss_count, 16);
    check("fl_hits", hit_count, 20);

    // Reset while a walk is outstanding
    @(negedge clk);
    tif.req_valid = 1'b1; tif.req_vaddr = 32'h0012_3000; tif.req_write = 1'b0;
    @(posedge clk); #1;
    tif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rw_walk_pending", tif.walk_req_valid, 1);
    check("rw_state_walk", dbg_state, 2);
    rst_n = 1'b0; #1;
    check("rw_walk_req", tif.walk_req_valid, 0);
    check("rw_state", dbg_state, 0);
    check("rw_ready", tif.req_ready, 1);
    check("rw_hits", hit_count, 0);
    check("rw_misses", miss_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tif.walk_resp_valid = 1'b1; tif.walk_ppn = 20'h55555; tif.walk_fault = 1'b0;
    @(posedge clk); #1;
    tif.walk_resp_valid = 1'b0;
    check("rw_stray_resp", tif.resp_valid, 0);
    check("rw_stray_state", dbg_state, 0);
    w_ppn = 20'hABCDE;
    access(32'h1234_5678, 1'b0);
    check("rw_cold_again", walks, 1);
    check("rw_cold_paddr", r_paddr, 32'hABCDE678);
    check("rw_cnt_miss", miss_count, 1);
    check("rw_cnt_hit", hit_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
